// File: rtl/wb_pipelined_master_bridge.sv
// wb_pipelined_master_bridge: picorv32 native port to a pipelined Wishbone B4 master, one access at a time,
// with ERR/timeout recovery and a sticky log of the first faulting address.
module wb_pipelined_master_bridge #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8,
  parameter logic [AW-1:0] WIN_BASE = 32'h8000_0000,
  parameter logic [AW-1:0] WIN_MASK = 32'hFFFF_FF00,
  parameter int TIMEOUT = 255,
  parameter logic [DW-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          i_mem_valid,
  input  logic [AW-1:0] i_mem_addr,
  input  logic [DW-1:0] i_mem_wdata,
  input  logic [SW-1:0] i_mem_wstrb,
  output logic          o_mem_hit,
  output logic          o_mem_ready,
  output logic [DW-1:0] o_mem_rdata,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  output logic [SW-1:0] o_wb_sel,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [DW-1:0] i_wb_data,
  output logic          o_err,
  output logic          o_err_timeout,
  output logic [AW-1:0] o_err_addr,
  input  logic          i_err_clr
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CLAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, err_addr_q, err_addr_d;
  logic [DW-1:0] data_q, data_d, rdata_q, rdata_d;
  logic [SW-1:0] sel_q, sel_d;
  logic we_q, we_d, err_q, err_d, err_to_q, err_to_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic take, bus_ack, bus_err, tmo, fault;
  assign o_mem_hit = i_mem_valid && ((i_mem_addr & WIN_MASK) == WIN_BASE);
  // Responses only count once the strobe has been accepted (REQ without stall) or while waiting.
  assign take = (state_q == S_REQ && !i_wb_stall) || state_q == S_WAIT;
  assign bus_err = take && i_wb_err;
  assign bus_ack = take && i_wb_ack && !i_wb_err;
  assign tmo = (TIMEOUT != 0) && state_q == S_WAIT && !i_wb_ack && !i_wb_err && cnt_q == CLAST;
  assign fault = bus_err || tmo;
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      data_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      rdata_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      err_to_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      sel_q <= sel_d;
      we_q <= we_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      err_to_q <= err_to_d;
      err_addr_q <= err_addr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = o_mem_hit ? S_REQ : S_IDLE;
      S_REQ:  state_d = i_wb_stall ? S_REQ : ((i_wb_ack || i_wb_err) ? S_RESP : S_WAIT);
      S_WAIT: state_d = (bus_ack || fault) ? S_RESP : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    sel_d = sel_q;
    we_d = we_q;
    rdata_d = rdata_q;
    cnt_d = state_q == S_WAIT ? (cnt_q == CMAX ? cnt_q : cnt_q + 1'b1) : '0;
    err_d = err_q;
    err_to_d = err_to_q;
    err_addr_d = err_addr_q;
    if (state_q == S_IDLE && o_mem_hit) begin
      addr_d = i_mem_addr;
      data_d = i_mem_wdata;
      we_d = |i_mem_wstrb;
      sel_d = |i_mem_wstrb ? i_mem_wstrb : '1;
    end
    if (bus_ack) rdata_d = we_q ? '0 : i_wb_data;
    if (fault) rdata_d = we_q ? '0 : ERR_RDATA;
    // Clear first so a fault in the same cycle is still logged.
    if (i_err_clr) begin
      err_d = 1'b0;
      err_to_d = 1'b0;
      err_addr_d = '0;
    end
    if (fault && !err_d) begin
      err_d = 1'b1;
      err_to_d = tmo;
      err_addr_d = addr_q;
    end
  end
  always_comb begin
    o_wb_cyc = state_q == S_REQ || state_q == S_WAIT;
    o_wb_stb = state_q == S_REQ;
    o_mem_ready = state_q == S_RESP;
  end
  assign o_wb_we = we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = data_q;
  assign o_wb_sel = sel_q;
  assign o_mem_rdata = rdata_q;
  assign o_err = err_q;
  assign o_err_timeout = err_to_q;
  assign o_err_addr = err_addr_q;
endmodule

// File: tb/tb_wb_pipelined_master_bridge.sv
// tb_wb_pipelined_master_bridge: directed and random CPU accesses against a cycle-level slave model,
// with read data scoreboarded through a queue and checked by an independent monitor.
module tb_wb_pipelined_master_bridge;
  localparam int T = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_mem_valid = 1'b0;
  logic [31:0] i_mem_addr = '0;
  logic [31:0] i_mem_wdata = '0;
  logic [3:0] i_mem_wstrb = '0;
  logic o_mem_hit, o_mem_ready, o_wb_cyc, o_wb_stb, o_wb_we, o_err, o_err_timeout;
  logic [31:0] o_mem_rdata, o_wb_addr, o_wb_data, o_err_addr;
  logic [3:0] o_wb_sel;
  logic i_wb_stall = 1'b0;
  logic i_wb_ack = 1'b0;
  logic i_wb_err = 1'b0;
  logic [31:0] i_wb_data = '0;
  logic i_err_clr = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic m_err = 1'b0;
  logic m_to = 1'b0;
  logic [31:0] m_addr = '0;
  always #5 clk = ~clk;
  wb_pipelined_master_bridge #(.TIMEOUT(T)) dut (
    .clk(clk), .i_reset(i_reset), .i_mem_valid(i_mem_valid), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_mem_wstrb(i_mem_wstrb), .o_mem_hit(o_mem_hit),
    .o_mem_ready(o_mem_ready), .o_mem_rdata(o_mem_rdata), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data),
    .o_err(o_err), .o_err_timeout(o_err_timeout), .o_err_addr(o_err_addr), .i_err_clr(i_err_clr)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (o_mem_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_ready: got rdata %h expected no completion", o_mem_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (o_mem_rdata !== mon_exp) begin
          n_bad++;
          $display("FAIL mem_rdata: got %h expected %h", o_mem_rdata, mon_exp);
        end
      end
    end
  end
  task automatic clr_log();
    @(negedge clk);
    i_err_clr = 1'b1;
    m_err = 1'b0;
    m_to = 1'b0;
    m_addr = '0;
    @(negedge clk);
    i_err_clr = 1'b0;
  endtask
  // resp: 0 ack, 1 err, 2 no response (timeout), 3 ack+err; zw: respond in the accepting cycle
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input int stall_n,
                     input int resp, input int lat, input bit zw, input logic [31:0] rd, input bit clr_at,
                     input bit drop_mid);
    bit hit, we;
    int fc, rc;
    hit = (a & 32'hFFFF_FF00) == 32'h8000_0000;
    we = ws != 4'h0;
    @(negedge clk);
    i_mem_valid = 1'b1;
    i_mem_addr = a;
    i_mem_wdata = wd;
    i_mem_wstrb = ws;
    #1;
    chk("mem_hit", o_mem_hit, hit);
    if (!hit) begin
      repeat (4) begin
        @(negedge clk);
        chk("miss_cyc", o_wb_cyc, 0);
      end
      i_mem_valid = 1'b0;
      return;
    end
    exp_q.push_back(we ? 32'h0 : (resp == 0 ? rd : ERRD));
    fc = resp == 2 ? 1 + stall_n + T : (zw ? 1 + stall_n : 2 + stall_n + lat);
    rc = fc + 1;
    for (int k = 1; k <= rc; k++) begin
      @(negedge clk);
      chk("wb_stb", o_wb_stb, k <= 1 + stall_n);
      chk("wb_cyc", o_wb_cyc, k < rc);
      chk("mem_ready", o_mem_ready, k == rc);
      if (k <= 1 + stall_n) begin
        chk("wb_addr", o_wb_addr, a);
        chk("wb_we", o_wb_we, we);
        chk("wb_sel", o_wb_sel, we ? ws : 4'hF);
        if (we) chk("wb_data", o_wb_data, wd);
      end
      if (k == rc) begin
        chk("err", o_err, m_err);
        chk("err_timeout", o_err_timeout, m_to);
        chk("err_addr", o_err_addr, m_addr);
      end
      i_wb_stall = k <= stall_n;
      i_wb_ack = k <= stall_n ? $urandom_range(0, 3) == 0 : (k == fc && (resp == 0 || resp == 3));
      i_wb_err = k <= stall_n ? $urandom_range(0, 3) == 0 : (k == fc && (resp == 1 || resp == 3));
      i_wb_data = k == fc ? rd : $urandom;
      i_err_clr = clr_at && k == fc;
      if (drop_mid && k == 2) i_mem_valid = 1'b0;
      if (k == fc) begin
        if (clr_at) begin
          m_err = 1'b0;
          m_to = 1'b0;
          m_addr = '0;
        end
        if (resp != 0 && !m_err) begin
          m_err = 1'b1;
          m_to = resp == 2;
          m_addr = a;
        end
      end
      if (k == rc) begin
        i_mem_valid = 1'b0;
        i_wb_stall = 1'b0;
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        i_err_clr = 1'b0;
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cyc", o_wb_cyc, 0);
    chk("rst_stb", o_wb_stb, 0);
    chk("rst_addr_sel", {o_wb_addr, o_wb_sel, o_wb_we}, 0);
    chk("rst_ready_rdata", {o_mem_ready, o_mem_rdata}, 0);
    chk("rst_err", {o_err, o_err_timeout, o_err_addr}, 0);
    i_reset = 1'b0;
    txn(32'h8000_0010, 0, 4'h0, 0, 0, 0, 0, 32'h0000_002A, 0, 0);
    txn(32'h8000_0000, 32'h3F, 4'b0001, 3, 0, 0, 0, 32'h1234_5678, 0, 0);
    clr_log();
    txn(32'h8000_0010, 0, 4'h0, 0, 1, 1, 0, 32'h5555_AAAA, 0, 0);
    clr_log();
    txn(32'h8000_0040, 0, 4'h0, 1, 2, 0, 0, 32'h0, 0, 0);
    txn(32'h8000_0080, 0, 4'h0, 0, 2, 0, 0, 32'h0, 0, 0);
    txn(32'h8000_0044, 0, 4'h0, 2, 3, 0, 1, 32'h0BAD_0BAD, 0, 0);
    txn(32'h8000_0048, 0, 4'h0, 0, 0, T - 1, 0, 32'hCAFE_F00D, 0, 0);
    txn(32'h8000_004C, 32'h77, 4'b1100, 0, 1, 0, 1, 32'h0, 1, 0);
    txn(32'h8000_0050, 0, 4'h0, 1, 0, 2, 0, 32'h0000_00C3, 0, 1);
    @(negedge clk);
    i_mem_valid = 1'b1;
    i_mem_addr = 32'h8000_0020;
    i_mem_wstrb = 4'h0;
    @(negedge clk);
    chk("rstw_stb", o_wb_stb, 1);
    @(negedge clk);
    chk("rstw_wait", {o_wb_cyc, o_wb_stb}, 2'b10);
    i_reset = 1'b1;
    i_mem_valid = 1'b0;
    @(negedge clk);
    i_reset = 1'b0;
    m_err = 1'b0;
    m_to = 1'b0;
    m_addr = '0;
    chk("rstw_cyc_stb", {o_wb_cyc, o_wb_stb}, 2'b00);
    chk("rstw_err", {o_err, o_err_addr}, 0);
    i_wb_ack = 1'b1;
    i_wb_data = 32'h1111_1111;
    repeat (3) begin
      @(negedge clk);
      chk("rstw_idle", {o_wb_cyc, o_mem_ready}, 2'b00);
    end
    i_wb_ack = 1'b0;
    txn(32'h0000_0100, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int r;
      r = $urandom_range(0, 9);
      a = r < 7 ? {24'h800000, 8'($urandom)} : (r == 7 ? {24'h800001, 8'($urandom)} : $urandom);
      r = $urandom_range(0, 9);
      txn(a, $urandom, $urandom_range(0, 1) ? 4'($urandom) : 4'h0, $urandom_range(0, 3),
          r < 5 ? 0 : (r < 7 ? 1 : (r < 9 ? 3 : 2)), $urandom_range(0, T - 1), $urandom_range(0, 1) == 1,
          $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) clr_log();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
